device_usb_core: RTL and testbench

Device-side counterpart of the console USB command core, sitting between the device's USB bag receive/transmit paths and its config/conversion engines. It announces itself with a DTYPE bag after reset, then decodes console command bags (DCONF, DCONV, CLINK) and runs the matching engine handshake. Each DCONF/DCONV is answered with a DTEMP/DATA reply bag. A link watchdog tracks console CLINK/command traffic and flags loss of link.

---
 rtl/device_usb_core_if.sv | 25 ++
 rtl/device_usb_core.sv | 162 ++++++++++++++++
 tb/tb_device_usb_core.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/device_usb_core_if.sv
// Bag receive/transmit and engine handshake bundle between the device core and its neighbours.
// master: the core (answers bags, issues transmit and engine starts).
// slave: the receive/transmit paths and the config/conversion engines.
interface device_usb_core_if;
  logic       fs_read;
  logic [3:0] read_btype;
  logic       fd_read;
  logic       fs_send;
  logic       fd_send;
  logic [3:0] send_btype;
  logic       fs_conf;
  logic       fd_conf;
  logic       fs_conv;
  logic       fd_conv;

  modport master (
    input  fs_read, read_btype, fd_send, fd_conf, fd_conv,
    output fd_read, fs_send, send_btype, fs_conf, fs_conv
  );

  modport slave (
    output fs_read, read_btype, fd_send, fd_conf, fd_conv,
    input  fd_read, fs_send, send_btype, fs_conf, fs_conv
  );
endinterface

// File: rtl/device_usb_core.sv
// Device USB command core: announces DTYPE, decodes console bags, runs engine handshakes, link watchdog.
// Latency: fs_read rise to fd_read 2 cycles; fs_read fall to engine start 1 cycle; all outputs registered/state-decoded.
// Backpressure: every handshake is a held level; the FSM waits indefinitely on fs_read/fd_conf/fd_conv/fd_send.
module device_usb_core #(
  parameter logic [31:0] DEVICE_IDX   = 32'h13579BDF,
  parameter logic [31:0] LINK_TIMEOUT = 32'd15_000_000,
  parameter logic [3:0]  DATA_IDX_NUM = 4'h6
) (
  input  logic               clk,
  input  logic               rst,
  device_usb_core_if.master  bus,
  output logic [3:0]         data_idx,
  output logic [31:0]        device_idx,
  output logic               link_ok,
  output logic [7:0]         bad_bag
);

  localparam logic [3:0] RX_DCONF = 4'b0001;
  localparam logic [3:0] RX_DCONV = 4'b1001;
  localparam logic [3:0] RX_CLINK = 4'b1011;
  localparam logic [3:0] TX_DTYPE = 4'b1001;
  localparam logic [3:0] TX_DTEMP = 4'b1010;
  localparam logic [3:0] TX_DATA  = 4'b0101;

  localparam logic [31:0] WD_MAX   = LINK_TIMEOUT - 32'd1;
  localparam logic [3:0]  IDX_LAST = DATA_IDX_NUM - 4'd1;

  typedef enum logic [3:0] {
    MAIN_IDLE,
    TYPE_SEND,
    MAIN_WAIT,
    READ_WORK,
    READ_DONE,
    CONF_WORK,
    CONF_WAIT,
    CONF_SEND,
    CONF_DONE,
    CONV_WORK,
    CONV_WAIT,
    CONV_SEND,
    CONV_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cmd;
  logic [3:0]  send_btype_q;
  logic [31:0] wd;

  logic fs_send_d;
  logic fd_read_d;
  logic fs_conf_d;
  logic fs_conv_d;
  logic valid_disp;
  logic bad_disp;

  assign bus.fs_send    = fs_send_d;
  assign bus.fd_read    = fd_read_d;
  assign bus.fs_conf    = fs_conf_d;
  assign bus.fs_conv    = fs_conv_d;
  assign bus.send_btype = send_btype_q;
  assign device_idx     = DEVICE_IDX;

  // State register; reset restarts the DTYPE announcement.
  always_ff @(posedge clk) begin
    if (rst) state <= MAIN_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; handshake strobes decode from the current state only.
  always_comb begin
    state_nxt  = state;
    fs_send_d  = 1'b0;
    fd_read_d  = 1'b0;
    fs_conf_d  = 1'b0;
    fs_conv_d  = 1'b0;
    valid_disp = 1'b0;
    bad_disp   = 1'b0;
    case (state)
      MAIN_IDLE: state_nxt = TYPE_SEND;
      TYPE_SEND: begin
        fs_send_d = 1'b1;
        if (bus.fd_send) state_nxt = MAIN_WAIT;
      end
      MAIN_WAIT: if (bus.fs_read) state_nxt = READ_WORK;
      READ_WORK: state_nxt = READ_DONE;
      READ_DONE: begin
        fd_read_d = 1'b1;
        if (!bus.fs_read) begin
          case (cmd)
            RX_DCONF: begin state_nxt = CONF_WORK; valid_disp = 1'b1; end
            RX_DCONV: begin state_nxt = CONV_WORK; valid_disp = 1'b1; end
            RX_CLINK: begin state_nxt = MAIN_WAIT; valid_disp = 1'b1; end
            default:  begin state_nxt = MAIN_WAIT; bad_disp   = 1'b1; end
          endcase
        end
      end
      CONF_WORK: begin
        fs_conf_d = 1'b1;
        if (bus.fd_conf) state_nxt = CONF_WAIT;
      end
      CONF_WAIT: if (!bus.fd_conf) state_nxt = CONF_SEND;
      CONF_SEND: begin
        fs_send_d = 1'b1;
        if (bus.fd_send) state_nxt = CONF_DONE;
      end
      CONF_DONE: state_nxt = MAIN_WAIT;
      CONV_WORK: begin
        fs_conv_d = 1'b1;
        if (bus.fd_conv) state_nxt = CONV_WAIT;
      end
      CONV_WAIT: if (!bus.fd_conv) state_nxt = CONV_SEND;
      CONV_SEND: begin
        fs_send_d = 1'b1;
        if (bus.fd_send) state_nxt = CONV_DONE;
      end
      CONV_DONE: state_nxt = MAIN_WAIT;
      default:   state_nxt = MAIN_IDLE;
    endcase
  end

  // Latch the bag type at acceptance so dispatch does not depend on read_btype after fs_read drops.
  always_ff @(posedge clk) begin
    if (rst)                                 cmd <= 4'h0;
    else if (state == MAIN_WAIT && bus.fs_read) cmd <= bus.read_btype;
  end

  // Reply type is loaded on entry to *_WAIT so it is settled a cycle before fs_send rises.
  always_ff @(posedge clk) begin
    if (rst)                                            send_btype_q <= 4'h0;
    else if (state == MAIN_IDLE)                        send_btype_q <= TX_DTYPE;
    else if (state == CONF_WORK && state_nxt == CONF_WAIT) send_btype_q <= TX_DTEMP;
    else if (state == CONV_WORK && state_nxt == CONV_WAIT) send_btype_q <= TX_DATA;
  end

  // Data frame index advances once per completed conversion reply.
  always_ff @(posedge clk) begin
    if (rst)                     data_idx <= 4'h0;
    else if (state == CONV_DONE) data_idx <= (data_idx == IDX_LAST) ? 4'h0 : data_idx + 4'h1;
  end

  // Saturating count of unrecognised command bags.
  always_ff @(posedge clk) begin
    if (rst)                           bad_bag <= 8'h00;
    else if (bad_disp && bad_bag != 8'hFF) bad_bag <= bad_bag + 8'h01;
  end

  // Link watchdog; a valid dispatch outranks a simultaneous expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= 32'd0;
      link_ok <= 1'b0;
    end else if (valid_disp) begin
      wd      <= 32'd0;
      link_ok <= 1'b1;
    end else begin
      if (wd != WD_MAX) wd <= wd + 32'd1;
      if (wd == WD_MAX) link_ok <= 1'b0;
    end
  end

endmodule

// File: tb/tb_device_usb_core.sv
// Self-checking bench for device_usb_core: randomized bag/engine/transmit timing against a
// cycle-count reference for the watchdog, saturating counters and the data index.
module tb_device_usb_core;

  localparam logic [31:0] LT    = 32'd100;
  localparam logic [3:0]  DCONF = 4'b0001;
  localparam logic [3:0]  DCONV = 4'b1001;
  localparam logic [3:0]  CLINK = 4'b1011;
  localparam logic [3:0]  DTYPE = 4'b1001;
  localparam logic [3:0]  DTEMP = 4'b1010;
  localparam logic [3:0]  DATA  = 4'b0101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  data_idx;
  logic [31:0] device_idx;
  logic        link_ok;
  logic [7:0]  bad_bag;

  device_usb_core_if bus();

  device_usb_core #(.LINK_TIMEOUT(LT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .data_idx   (data_idx),
    .device_idx (device_idx),
    .link_ok    (link_ok),
    .bad_bag    (bad_bag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_hits = 0;
  always @(negedge clk) if (bus.fd_read) rd_hits <= rd_hits + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle of the last valid dispatch, bad-bag count, data frame index.
  int last_disp  = 0;
  bit valid_seen = 1'b0;
  int m_bad      = 0;
  int m_idx      = 0;

  function automatic bit is_valid(input logic [3:0] code);
    return (code == DCONF) || (code == DCONV) || (code == CLINK);
  endfunction

  function automatic bit exp_link();
    return valid_seen && ((cyc - last_disp) < int'(LT));
  endfunction

  // Present a bag, wait for fd_read, hold `hold` extra cycles, release. Returns one negedge after release.
  task automatic present_bag(input logic [3:0] code, input int hold, output int lat, output bit ok);
    bus.fs_read = 1'b1;
    bus.read_btype = code;
    lat = 0;
    ok = 1'b0;
    while (!ok && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.fd_read) ok = 1'b1;
    end
    repeat (hold) @(negedge clk);
    bus.fs_read = 1'b0;
    if (ok) begin
      if (is_valid(code)) begin
        valid_seen = 1'b1;
        last_disp = cyc + 1;
      end else if (m_bad < 255) begin
        m_bad++;
      end
    end
    @(negedge clk);
  endtask

  // Engine: counts n cycles of the start strobe, then raises done until the strobe drops.
  task automatic serve_eng(input bit conv, input int n, output int hi, output bit dropped);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (conv ? bus.fs_conv : bus.fs_conf) hi++;
      if (i < n - 1) @(negedge clk);
    end
    if (conv) bus.fd_conv = 1'b1;
    else      bus.fd_conf = 1'b1;
    @(negedge clk);
    dropped = !(conv ? bus.fs_conv : bus.fs_conf);
    bus.fd_conv = 1'b0;
    bus.fd_conf = 1'b0;
  endtask

  // Transmit path: waits for fs_send, acknowledges after `delay` cycles of fs_send.
  task automatic serve_send(input int delay, output int lat, output logic [3:0] pre_bt,
                            output logic [3:0] bt, output bit stable, output bit dropped);
    pre_bt = bus.send_btype;
    lat = 0;
    bt = 4'h0;
    stable = 1'b0;
    dropped = 1'b0;
    while (!bus.fs_send && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (bus.fs_send) begin
      bt = bus.send_btype;
      stable = 1'b1;
      for (int i = 1; i < delay; i++) begin
        @(negedge clk);
        if (!bus.fs_send || bus.send_btype !== bt) stable = 1'b0;
      end
      bus.fd_send = 1'b1;
      @(negedge clk);
      dropped = !bus.fs_send;
      bus.fd_send = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lat; bit ok; logic [3:0] pre, bt; bit st, dr;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.fs_send !== 1'b0)    begin errors++; $display("FAIL rst_fs_send: got %b want 0", bus.fs_send); end
    checks++; if (bus.fd_read !== 1'b0)    begin errors++; $display("FAIL rst_fd_read: got %b want 0", bus.fd_read); end
    checks++; if (bus.fs_conf !== 1'b0 || bus.fs_conv !== 1'b0)
      begin errors++; $display("FAIL rst_engines: got conf=%b conv=%b want 0", bus.fs_conf, bus.fs_conv); end
    checks++; if (bus.send_btype !== 4'h0) begin errors++; $display("FAIL rst_send_btype: got %h want 0", bus.send_btype); end
    checks++; if (data_idx !== 4'h0 || link_ok !== 1'b0 || bad_bag !== 8'h00)
      begin errors++; $display("FAIL rst_regs: got idx=%0d link=%b bad=%0d want 0", data_idx, link_ok, bad_bag); end
    checks++; if (device_idx !== 32'h13579BDF) begin errors++; $display("FAIL device_idx: got %h want 13579bdf", device_idx); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    // First cycle after release is MAIN_IDLE, so no request yet.
    checks++; if (bus.fs_send !== 1'b0) begin errors++; $display("FAIL type_early: got fs_send=%b want 0", bus.fs_send); end
    serve_send(5, lat, pre, bt, st, dr);
    checks++; if (lat !== 1) begin errors++; $display("FAIL type_lat: got %0d want 1 more cycle", lat); end
    checks++; if (bt !== DTYPE || !st) begin errors++; $display("FAIL type_btype: got %b stable=%b want 1001", bt, st); end
    checks++; if (!dr) begin errors++; $display("FAIL type_drop: fs_send still high after fd_send"); end
    checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL type_link: got %b want 0", link_ok); end
    // Already in MAIN_WAIT: a bag is answered in 2 cycles.
    present_bag(CLINK, 0, lat, ok);
    checks++; if (!ok || lat !== 2) begin errors++; $display("FAIL type_wait: fd_read lat got %0d want 2", lat); end
    checks++; if (link_ok !== exp_link()) begin errors++; $display("FAIL clink_link: got %b want %b", link_ok, exp_link()); end
  endtask

  task automatic test_conf();
    int lat, hi, rd0; bit ok, dr, st; logic [3:0] pre, bt;
    present_bag(DCONF, 1, lat, ok);
    checks++; if (!ok || lat !== 2) begin errors++; $display("FAIL conf_rd_lat: got %0d want 2", lat); end
    checks++; if (bus.fd_read !== 1'b0 || bus.fs_conf !== 1'b1)
      begin errors++; $display("FAIL conf_start: got fd_read=%b fs_conf=%b want 0/1", bus.fd_read, bus.fs_conf); end
    rd0 = rd_hits;
    serve_eng(1'b0, 10, hi, dr);
    checks++; if (hi !== 10 || !dr) begin errors++; $display("FAIL conf_len: got %0d cycles drop=%b want 10", hi, dr); end
    serve_send(int'($urandom_range(6, 1)), lat, pre, bt, st, dr);
    checks++; if (lat !== 1) begin errors++; $display("FAIL conf_send_lat: got %0d want 1", lat); end
    checks++; if (pre !== DTEMP || bt !== DTEMP || !st || !dr)
      begin errors++; $display("FAIL conf_btype: got pre=%b bt=%b st=%b dr=%b want 1010", pre, bt, st, dr); end
    checks++; if (rd_hits !== rd0) begin errors++; $display("FAIL conf_stray_rd: got %0d fd_read cycles want 0", rd_hits - rd0); end
    checks++; if (link_ok !== 1'b1 || link_ok !== exp_link())
      begin errors++; $display("FAIL conf_link: got %b want 1", link_ok); end
    // One *_DONE cycle sits between the reply and MAIN_WAIT.
    present_bag(CLINK, 0, lat, ok);
    checks++; if (!ok || lat !== 3) begin errors++; $display("FAIL conf_done_lat: got %0d want 3", lat); end
  endtask

  task automatic test_conv();
    int lat, hi, n; bit ok, dr, st; logic [3:0] pre, bt;
    for (int k = 0; k < 7; k++) begin
      present_bag(DCONV, int'($urandom_range(3, 0)), lat, ok);
      checks++; if (!ok || lat !== 2 || bus.fs_conv !== 1'b1)
        begin errors++; $display("FAIL conv_start[%0d]: lat=%0d fs_conv=%b want 2/1", k, lat, bus.fs_conv); end
      n = int'($urandom_range(12, 1));
      serve_eng(1'b1, n, hi, dr);
      checks++; if (hi !== n || !dr) begin errors++; $display("FAIL conv_len[%0d]: got %0d want %0d", k, hi, n); end
      serve_send(int'($urandom_range(6, 1)), lat, pre, bt, st, dr);
      checks++; if (lat !== 1 || pre !== DATA || bt !== DATA || !st || !dr)
        begin errors++; $display("FAIL conv_reply[%0d]: lat=%0d bt=%b want 1/0101", k, lat, bt); end
      @(negedge clk);
      m_idx = (m_idx + 1) % 6;
      checks++; if (data_idx !== 4'(m_idx)) begin errors++; $display("FAIL conv_idx[%0d]: got %0d want %0d", k, data_idx, m_idx); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, hi, rd0, n; bit ok, dr, st; logic [3:0] pre, bt;
    present_bag(DCONF, 0, lat, ok);
    // Next bag presented while the config handshake is running must wait for MAIN_WAIT.
    bus.fs_read = 1'b1;
    bus.read_btype = CLINK;
    rd0 = rd_hits;
    n = int'($urandom_range(8, 3));
    serve_eng(1'b0, n, hi, dr);
    serve_send(2, lat, pre, bt, st, dr);
    checks++; if (rd_hits !== rd0 || hi !== n || bt !== DTEMP)
      begin errors++; $display("FAIL b2b_ignored: rd=%0d len=%0d bt=%b want 0/%0d/1010", rd_hits - rd0, hi, bt, n); end
    present_bag(CLINK, 0, lat, ok);
    checks++; if (!ok || lat !== 3) begin errors++; $display("FAIL b2b_accept: lat got %0d want 3", lat); end
    checks++; if (link_ok !== exp_link()) begin errors++; $display("FAIL b2b_link: got %b want %b", link_ok, exp_link()); end
  endtask

  task automatic test_bad_bag();
    int lat; bit ok, busy; logic [3:0] code;
    present_bag(4'b0111, 0, lat, ok);
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.fs_conf || bus.fs_conv || bus.fs_send) busy = 1'b1;
      @(negedge clk);
    end
    present_bag(4'b1111, 0, lat, ok);
    checks++; if (busy || bus.fs_conf || bus.fs_conv || bus.fs_send)
      begin errors++; $display("FAIL bad_no_handshake: an engine or send strobe was raised"); end
    checks++; if (bad_bag !== 8'(m_bad)) begin errors++; $display("FAIL bad_count2: got %0d want %0d", bad_bag, m_bad); end
    checks++; if (link_ok !== exp_link()) begin errors++; $display("FAIL bad_link: got %b want %b", link_ok, exp_link()); end
    for (int i = 0; i < 300; i++) begin
      do code = 4'($urandom_range(15, 0)); while (is_valid(code));
      present_bag(code, int'($urandom_range(2, 0)), lat, ok);
      checks++; if (!ok || bad_bag !== 8'(m_bad))
        begin errors++; $display("FAIL bad_count[%0d]: code=%b got %0d want %0d", i, code, bad_bag, m_bad); end
    end
    checks++; if (bad_bag !== 8'hFF) begin errors++; $display("FAIL bad_saturate: got %0d want 255", bad_bag); end
  endtask

  task automatic test_watchdog();
    int lat; bit ok, l99, l100;
    present_bag(CLINK, 0, lat, ok);
    for (int k = 0; k < 4; k++) begin
      while (cyc - last_disp < 76) begin
        @(negedge clk);
        checks++; if (link_ok !== exp_link()) begin errors++; $display("FAIL wd_keep[%0d]: got %b want %b", k, link_ok, exp_link()); end
      end
      present_bag(CLINK, 0, lat, ok);
    end
    // Dispatch lands on the very edge the watchdog would expire.
    while (cyc - last_disp < 97) @(negedge clk);
    present_bag(CLINK, 0, lat, ok);
    checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL wd_race: got %b want 1", link_ok); end
    l99 = 1'b0;
    l100 = 1'b1;
    while (cyc - last_disp < 105) begin
      @(negedge clk);
      if (cyc - last_disp == 99)  l99  = link_ok;
      if (cyc - last_disp == 100) l100 = link_ok;
      checks++; if (link_ok !== exp_link()) begin errors++; $display("FAIL wd_track: elapsed=%0d got %b want %b", cyc - last_disp, link_ok, exp_link()); end
    end
    checks++; if (l99 !== 1'b1 || l100 !== 1'b0) begin errors++; $display("FAIL wd_edge: got at99=%b at100=%b want 1/0", l99, l100); end
    present_bag(CLINK, 0, lat, ok);
    checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL wd_restore: got %b want 1", link_ok); end
  endtask

  task automatic test_reset_mid();
    int lat, hi, t; bit ok, dr, st; logic [3:0] pre, bt;
    present_bag(DCONV, 0, lat, ok);
    serve_eng(1'b1, int'($urandom_range(6, 2)), hi, dr);
    t = 0;
    while (!bus.fs_send && t < 50) begin @(negedge clk); t++; end
    checks++; if (bus.fs_send !== 1'b1 || data_idx !== 4'(m_idx))
      begin errors++; $display("FAIL mid_pre: fs_send=%b idx=%0d want 1/%0d", bus.fs_send, data_idx, m_idx); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.fs_send !== 1'b0 || bus.fs_conv !== 1'b0 || data_idx !== 4'h0)
      begin errors++; $display("FAIL mid_drop: fs_send=%b fs_conv=%b idx=%0d want 0", bus.fs_send, bus.fs_conv, data_idx); end
    checks++; if (link_ok !== 1'b0 || bad_bag !== 8'h00)
      begin errors++; $display("FAIL mid_regs: link=%b bad=%0d want 0", link_ok, bad_bag); end
    m_idx = 0;
    m_bad = 0;
    valid_seen = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    serve_send(3, lat, pre, bt, st, dr);
    checks++; if (lat !== 1 || bt !== DTYPE || !dr)
      begin errors++; $display("FAIL mid_dtype: lat=%0d bt=%b want 1/1001", lat, bt); end
  endtask

  initial begin
    bus.fs_read = 1'b0;
    bus.read_btype = 4'h0;
    bus.fd_send = 1'b0;
    bus.fd_conf = 1'b0;
    bus.fd_conv = 1'b0;
    test_reset();
    test_conf();
    test_conv();
    test_back_to_back();
    test_bad_bag();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
